// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: derives BCLK/LRCLK from clk and serializes one
// buffered sample pair per frame, MSB first, one BCLK after each LRCLK edge.
module audio_i2s_tx #(
  parameter int SAMPLE_W  = 16,
  parameter int BCLK_HALF = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                in_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                dacdat,
  output logic                underrun
);

  localparam int                PH_W      = $clog2(2 * BCLK_HALF);
  localparam logic [PH_W-1:0]   PH_ZERO   = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * BCLK_HALF - 1);
  localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(BCLK_HALF);
  localparam logic [5:0]        SLOT_LAST = 6'd63;
  localparam logic [5:0]        WORD_BITS = 6'(SAMPLE_W);
  localparam logic [SAMPLE_W-1:0] WORD_ZERO = {SAMPLE_W{1'b0}};

  logic [PH_W-1:0]     ph_r, ph_s;
  logic [5:0]          slot_r, slot_s;
  logic                bclk_r, bclk_s;
  logic                lrclk_r, lrclk_s;
  logic                dacdat_r, dacdat_s;
  logic                underrun_r, underrun_s;
  logic                in_ready_r;
  logic                hold_full_r, hold_full_s;
  logic [SAMPLE_W-1:0] hold_left_r, hold_left_s;
  logic [SAMPLE_W-1:0] hold_right_r, hold_right_s;
  logic [SAMPLE_W-1:0] word_left_r, word_left_s;
  logic [SAMPLE_W-1:0] word_right_r, word_right_s;
  logic [SAMPLE_W-1:0] chan_word_s, word_shifted_s;
  logic [5:0]          bit_k_s, shift_s;
  logic                ph_wrap_s, frame_load_s;

  assign ph_wrap_s    = (ph_r == PH_LAST);
  assign frame_load_s = en & ph_wrap_s & (slot_r == SLOT_LAST);

  // Phase and slot counters: parked at zero while disabled.
  always_comb begin
    ph_s   = ph_r;
    slot_s = slot_r;
    if (!en) begin
      ph_s   = PH_ZERO;
      slot_s = 6'd0;
    end else if (ph_wrap_s) begin
      ph_s   = PH_ZERO;
      slot_s = slot_r + 6'd1;
    end else begin
      ph_s   = ph_r + PH_ONE;
      slot_s = slot_r;
    end
  end

  // Frame words and holding register; an empty holding register at a frame
  // load lets a sample offered in that very cycle bypass straight into the frame.
  always_comb begin
    word_left_s  = word_left_r;
    word_right_s = word_right_r;
    hold_full_s  = hold_full_r;
    hold_left_s  = hold_left_r;
    hold_right_s = hold_right_r;
    underrun_s   = 1'b0;

    if (frame_load_s) begin
      if (hold_full_r) begin
        word_left_s  = hold_left_r;
        word_right_s = hold_right_r;
      end else if (in_valid) begin
        word_left_s  = in_left;
        word_right_s = in_right;
      end else begin
        word_left_s  = WORD_ZERO;
        word_right_s = WORD_ZERO;
        underrun_s   = 1'b1;
      end
    end else if (!en) begin
      word_left_s  = WORD_ZERO;
      word_right_s = WORD_ZERO;
    end else begin
      word_left_s  = word_left_r;
      word_right_s = word_right_r;
    end

    if (frame_load_s && hold_full_r) begin
      hold_full_s = 1'b0;
    end else if (!frame_load_s && in_valid && !hold_full_r) begin
      hold_full_s  = 1'b1;
      hold_left_s  = in_left;
      hold_right_s = in_right;
    end else begin
      hold_full_s  = hold_full_r;
      hold_left_s  = hold_left_r;
      hold_right_s = hold_right_r;
    end
  end

  // Serial outputs computed from next-state counters so all three flops move together.
  always_comb begin
    bclk_s         = en & (ph_s >= PH_HIGH);
    lrclk_s        = slot_s[5];
    chan_word_s    = slot_s[5] ? word_right_s : word_left_s;
    bit_k_s        = {1'b0, slot_s[4:0]};
    shift_s        = WORD_BITS - bit_k_s;
    word_shifted_s = chan_word_s >> shift_s;
    if ((bit_k_s != 6'd0) && (bit_k_s <= WORD_BITS)) begin
      dacdat_s = word_shifted_s[0];
    end else begin
      dacdat_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_r         <= PH_ZERO;
      slot_r       <= 6'd0;
      bclk_r       <= 1'b0;
      lrclk_r      <= 1'b0;
      dacdat_r     <= 1'b0;
      underrun_r   <= 1'b0;
      in_ready_r   <= 1'b1;
      hold_full_r  <= 1'b0;
      hold_left_r  <= WORD_ZERO;
      hold_right_r <= WORD_ZERO;
      word_left_r  <= WORD_ZERO;
      word_right_r <= WORD_ZERO;
    end else begin
      ph_r         <= ph_s;
      slot_r       <= slot_s;
      bclk_r       <= bclk_s;
      lrclk_r      <= lrclk_s;
      dacdat_r     <= dacdat_s;
      underrun_r   <= underrun_s;
      in_ready_r   <= ~hold_full_s;
      hold_full_r  <= hold_full_s;
      hold_left_r  <= hold_left_s;
      hold_right_r <= hold_right_s;
      word_left_r  <= word_left_s;
      word_right_r <= word_right_s;
    end
  end

  assign in_ready = in_ready_r;
  assign bclk     = bclk_r;
  assign lrclk    = lrclk_r;
  assign dacdat   = dacdat_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: accepted pairs are queued and compared frame by frame
// against the captured serial stream; handshake, enable and reset corners by hand.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
  localparam int SAMPLE_W  = 16;
  localparam int BCLK_HALF = 3;
  localparam int FRAME_CLK = 64 * 2 * BCLK_HALF;

  logic                clk = 1'b0;
  logic                rst_n, en, in_valid;
  logic [SAMPLE_W-1:0] in_left, in_right;
  logic                in_ready, bclk, lrclk, dacdat, underrun;

  always #5 clk = ~clk;

  audio_i2s_tx #(.SAMPLE_W(SAMPLE_W), .BCLK_HALF(BCLK_HALF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_left(in_left), .in_right(in_right), .in_ready(in_ready),
    .bclk(bclk), .lrclk(lrclk), .dacdat(dacdat), .underrun(underrun)
  );

  typedef struct packed { logic [15:0] l; logic [15:0] r; } pair_t;
  typedef struct { logic [15:0] l; logic [15:0] r; logic gap; } vec_t;

  pair_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int frames_started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 1; k <= SAMPLE_W; k++) begin
      v[k]      = l[SAMPLE_W-k];
      v[32 + k] = r[SAMPLE_W-k];
    end
    return v;
  endfunction

  // Monitor: slices the stream on BCLK rising edges, one frame per LRCLK fall.
  logic        bclk_p = 1'b0, lrclk_p = 1'b0, dac_p = 1'b0, run_p = 1'b0, run_now;
  logic        cap_valid = 1'b0, lr_ok = 1'b0;
  logic [63:0] cap_d, cap_lr;
  pair_t       exp_pair;
  int          bit_idx = 0, last_rise = 0, last_lr = 0, sync_err = 0, extra_uf = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      run_now = en && rst_n;
      if (!run_now) begin
        cap_valid = 1'b0;
        lr_ok     = 1'b0;
      end else if (!run_p) begin
        cap_valid = 1'b1;
        exp_pair  = '0;
        bit_idx   = 0;
        cap_d     = 64'd0;
        cap_lr    = 64'd0;
        sync_err  = 0;
        extra_uf  = underrun ? 1 : 0;
      end else begin
        if (lrclk_p && !lrclk) begin
          if (cap_valid) begin
            chk("frame_data", cap_d, frame_bits(exp_pair.l, exp_pair.r));
            chk("frame_lrclk", cap_lr, 64'hFFFF_FFFF_0000_0000);
            chk("frame_bitcount", 64'(bit_idx), 64'd64);
            chk("frame_timing", 64'(sync_err), 64'd0);
            chk("extra_underrun", 64'(extra_uf), 64'd0);
          end
          if (sb_q.size() > 0) begin
            exp_pair = sb_q.pop_front();
            chk("underrun_at_load", 64'(underrun), 64'd0);
          end else begin
            exp_pair = '0;
            chk("underrun_at_load", 64'(underrun), 64'd1);
          end
          frame_start_cyc = cyc;
          frames_started++;
          cap_valid = 1'b1;
          bit_idx   = 0;
          cap_d     = 64'd0;
          cap_lr    = 64'd0;
          sync_err  = 0;
          extra_uf  = 0;
        end else if (underrun) begin
          extra_uf++;
        end
        if ((lrclk != lrclk_p || dacdat != dac_p) && !(bclk_p && !bclk)) sync_err++;
        if (!lrclk_p && lrclk) begin
          if (lr_ok && (cyc - last_lr != FRAME_CLK)) sync_err++;
          last_lr = cyc;
          lr_ok   = 1'b1;
        end
        if (bclk && !bclk_p) begin
          if (bit_idx > 0 && (cyc - last_rise != 2 * BCLK_HALF)) sync_err++;
          last_rise = cyc;
          if (bit_idx < 64) begin
            cap_d[bit_idx]  = dacdat;
            cap_lr[bit_idx] = lrclk;
          end
          bit_idx++;
        end
      end
      bclk_p  = bclk;
      lrclk_p = lrclk;
      dac_p   = dacdat;
      run_p   = run_now;
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int waited);
    pair_t p;
    waited   = 0;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    while (!in_ready && waited < 2 * FRAME_CLK) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      p.l = l;
      p.r = r;
      sb_q.push_back(p);
    end else begin
      chk("send_timeout", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target;
    int t;
    target = frames_started + n;
    t = 0;
    while (frames_started < target && t < n * (FRAME_CLK + 16) + 16) begin
      @(negedge clk);
      t++;
    end
    chk("frame_wait", 64'(frames_started >= target), 64'd1);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 2 * FRAME_CLK) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_cyc(input int target);
    int t;
    t = 0;
    while (cyc < target && t < 2 * FRAME_CLK) begin
      @(negedge clk);
      t++;
    end
    chk("cycle_wait", 64'(cyc), 64'(target));
  endtask

  initial begin
    vec_t vecs[5];
    int   waited;
    int   quiet_err;
    int   t;

    vecs[0] = '{16'hA5F0, 16'h0F0F, 1'b0};
    vecs[1] = '{16'h1234, 16'h8001, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h8000, 1'b1};
    vecs[4] = '{16'h0001, 16'hFFFE, 1'b0};

    // Reset with enable and a pending sample: everything quiet, nothing taken.
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_left = 16'hDEAD; in_right = 16'hBEEF;
    repeat (4) @(negedge clk);
    chk("rst_outputs", 64'({bclk, lrclk, dacdat, underrun}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_outputs", 64'({bclk, lrclk, dacdat, underrun}), 64'd0);

    // Table: first pair goes in during the silent frame, the rest back to back.
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].gap) begin
        wait_ready();
        wait_frames(1);
      end
      send(vecs[i].l, vecs[i].r, waited);
      if (i == 0) chk("first_accept_wait", 64'(waited), 64'd0);
    end
    t = 0;
    while (sb_q.size() > 0 && t < 4 * FRAME_CLK) begin
      @(negedge clk);
      t++;
    end
    wait_frames(1);

    // Back-to-back pairs: second waits for the load, accepted the cycle after.
    wait_frames(1);
    repeat (10) @(negedge clk);
    send(16'h1357, 16'h2468, waited);
    chk("b2b_first_wait", 64'(waited), 64'd0);
    in_left = 16'hC3C3; in_right = 16'h3C3C; in_valid = 1'b1;
    chk("b2b_ready_low", 64'(in_ready), 64'd0);
    t = 0;
    while (!in_ready && t < FRAME_CLK + 20) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_ready_rise_cycle", 64'(cyc), 64'(frame_start_cyc));
    chk("b2b_ready_rise", 64'(in_ready), 64'd1);
    if (in_ready) sb_q.push_back({16'hC3C3, 16'h3C3C});
    @(negedge clk);
    in_valid = 1'b0;

    // Starve: second pair plays, then an underrun frame.
    wait_frames(2);

    // Bypass: offer a pair only on the load cycle with the holding register empty.
    wait_cyc(frame_start_cyc + FRAME_CLK - 1);
    in_left = 16'h8421; in_right = 16'h1248; in_valid = 1'b1;
    chk("bypass_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb_q.push_back({16'h8421, 16'h1248});
    @(negedge clk);
    in_valid = 1'b0;
    chk("bypass_load_now", 64'(cyc), 64'(frame_start_cyc));
    chk("bypass_hold_empty", 64'(in_ready), 64'd1);
    wait_frames(1);

    // Drop enable mid-frame with a held pair: idle, pair kept, silent frame first.
    repeat (20) @(negedge clk);
    send(16'h00FF, 16'hFF00, waited);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en0_outputs", 64'({bclk, lrclk, dacdat}), 64'd0);
    chk("en0_hold_full", 64'(in_ready), 64'd0);
    quiet_err = 0;
    repeat (FRAME_CLK + 10) begin
      @(negedge clk);
      if (underrun || bclk || lrclk || dacdat) quiet_err++;
    end
    chk("en0_quiet", 64'(quiet_err), 64'd0);
    chk("en0_hold_kept", 64'(in_ready), 64'd0);
    en = 1'b1;
    wait_frames(2);

    // Reset at right-channel slot 20 with a full holding register.
    repeat (5) @(negedge clk);
    send(16'hBAD0, 16'h0BAD, waited);
    wait_cyc(frame_start_cyc + 52 * 2 * BCLK_HALF + 2);
    chk("pre_rst_lrclk", 64'(lrclk), 64'd1);
    chk("pre_rst_hold_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_outputs", 64'({bclk, lrclk, dacdat, underrun}), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
